// File: rtl/mips4_pkg.sv
// mips4_pkg: shared widths and responder state type for the 4-bit processor's data-memory port.
package mips4_pkg;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 4;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: 16x4 word store, synchronous write and clear, combinational read.
module data_mem_array
    import mips4_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    always_ff @(posedge clk) begin
        if (!rst_n) mem <= '0;
        else if (we) mem[addr] <= wdata;
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready load/store responder with programmable load latency,
// one load outstanding at a time.
module data_mem_responder
    import mips4_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int DEPTH        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);
    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);
    resp_state_t       state, state_d;
    logic [1:0]        lat_cnt;
    logic [DATA_W-1:0] rdata_q, mem_rdata;
    logic              accept, load_acc;
    assign req_ready = state == IDLE;
    assign accept    = req_valid && req_ready;
    assign load_acc  = accept && !req_write;
    assign rsp_valid = state == RESP;
    assign rsp_rdata = rdata_q;
    assign busy      = state != IDLE;
    data_mem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && req_write),
        .addr  (req_addr),
        .wdata (req_wdata),
        .rdata (mem_rdata)
    );
    always_comb begin
        state_d = state;
        state_d = load_acc                        ? (READ_LATENCY == 1 ? RESP : WAIT) :
                  (state == WAIT && lat_cnt == 2'd1) ? RESP :
                  (state == RESP && rsp_ready)       ? IDLE : state;
    end
    // Load data is snapshotted at acceptance; no store can slip in while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_d;
            if (load_acc) begin
                rdata_q <= mem_rdata;
                lat_cnt <= LAT_INIT;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized check of three responders (latency 2, 1, 4) against an array/latency model.
module tb_data_mem_responder;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       req_write = 0;
    logic [3:0] req_addr = 0;
    logic [3:0] req_wdata = 0;
    logic       rsp_ready = 0;
    logic       req_valid [3];
    logic       req_ready [3];
    logic       rsp_valid [3];
    logic       busy      [3];
    logic [3:0] rsp_rdata [3];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] m [3][16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(.READ_LATENCY(g == 0 ? 2 : g == 1 ? 1 : 4)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready),
            .rsp_rdata (rsp_rdata[g]),
            .busy      (busy[g])
        );
    end

    function automatic int lat_of(input int i);
        return i == 0 ? 2 : i == 1 ? 1 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < 16; a++) m[i][a] = 4'h0;
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, "_rdy"}, req_ready[i], 1);
        check({tag, "_vld"}, rsp_valid[i], 0);
        check({tag, "_busy"}, busy[i], 0);
    endtask

    task automatic store(input int i, input logic [3:0] a, input logic [3:0] d);
        req_valid[i] = 1;
        req_write = 1;
        req_addr = a;
        req_wdata = d;
        check("store_rdy", req_ready[i], 1);
        tick;
        req_valid[i] = 0;
        m[i][a] = d;
    endtask

    task automatic load(input int i, input logic [3:0] a, input int stall);
        int n;
        rsp_ready = 0;
        req_valid[i] = 1;
        req_write = 0;
        req_addr = a;
        check("load_rdy", req_ready[i], 1);
        tick;
        req_valid[i] = 0;
        n = 1;
        while (!rsp_valid[i] && n < 10) begin
            check("wait_rdy", req_ready[i], 0);
            check("wait_busy", busy[i], 1);
            tick;
            n++;
        end
        check("latency", n, lat_of(i));
        for (int s = 0; s < stall; s++) begin
            check("stall_vld", rsp_valid[i], 1);
            check("stall_data", rsp_rdata[i], m[i][a]);
            check("stall_rdy", req_ready[i], 0);
            req_valid[i] = 1;
            req_write = 1;
            req_addr = a;
            req_wdata = 4'($urandom);
            tick;
        end
        req_valid[i] = 0;
        rsp_ready = 1;
        check("rsp_vld", rsp_valid[i], 1);
        check("rsp_data", rsp_rdata[i], m[i][a]);
        tick;
        rsp_ready = 0;
        check_idle(i, "post_rsp");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) req_valid[i] = 0;
        clear_model();
        req_valid[0] = 1;
        req_write = 1;
        req_addr = 4;
        req_wdata = 4'hC;
        tick;
        tick;
        req_valid[0] = 0;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            check_idle(i, "reset");
            check("reset_data", rsp_rdata[i], 0);
        end
        load(0, 4'd5, 0);
        load(0, 4'd4, 0);
        store(0, 4'd3, 4'hA);
        load(0, 4'd3, 0);
        store(0, 4'd7, 4'h5);
        load(0, 4'd7, 4);
        load(0, 4'd7, 0);
        for (int a = 0; a < 15; a++) store(0, 4'(a), 4'(a + 1));
        for (int a = 0; a < 16; a++) load(0, 4'(a), 0);
        store(0, 4'd2, 4'h9);
        rsp_ready = 1;
        req_valid[0] = 1;
        req_write = 0;
        req_addr = 2;
        tick;
        req_valid[0] = 0;
        check("midload_busy", busy[0], 1);
        rst_n = 0;
        tick;
        rst_n = 1;
        clear_model();
        check_idle(0, "midload_rst");
        for (int k = 0; k < 6; k++) begin
            check("dropped_rsp", rsp_valid[0], 0);
            tick;
        end
        load(0, 4'd2, 0);
        load(0, 4'd14, 0);
        for (int i = 1; i < 3; i++) begin
            store(i, 4'd6, 4'(i + 3));
            load(i, 4'd6, 1);
            load(i, 4'd0, 0);
        end
        for (int k = 0; k < 200; k++) begin
            int i;
            logic [3:0] a;
            i = $urandom_range(0, 2);
            a = 4'($urandom);
            if ($urandom_range(0, 1) == 1) store(i, a, 4'($urandom));
            else load(i, a, $urandom_range(0, 3));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the 4-bit processor's data-memory port. It owns a 16-entry × 4-bit data store and serves load/store requests over a valid/ready request channel. Load data returns on a valid/ready response channel after a programmable latency, and only one load is outstanding at a time. It sits between the processor datapath (initiator) and the data storage, replacing the single-cycle memory where realistic memory latency must be modelled.

## Interface
- `READ_LATENCY`, default 2: cycles from load acceptance to `rsp_valid`; legal range 1..4.
- `DEPTH`, default 16: number of 4-bit words. The address is always 4 bits, so the design only supports DEPTH = 16.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `req_valid`  in  1  initiator presents a request.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  4  word address.
- `req_wdata`  in  4  store data.
- `rsp_valid`  out  1  load data is valid.
- `rsp_ready`  in  1  initiator consumes the response.
- `rsp_rdata`  out  4  load data.
- `busy`  out  1  a load is in flight or its response is pending.

## Operation
- A request is accepted on a rising edge where `req_valid && req_ready`.
- FSM states: `IDLE`, `WAIT`, `RESP`.
- `IDLE`:
  - `req_ready` = 1.
  - Accepted store: writes `mem[req_addr] <= req_wdata` at the accept edge. The FSM stays in `IDLE`; no response is generated.
  - Accepted load: captures `mem[req_addr]` into `rdata_q` at the accept edge and loads `lat_cnt <= READ_LATENCY-1`.
    - If `READ_LATENCY` = 1, the next state is `RESP`.
    - Otherwise the next state is `WAIT`.
- `WAIT`:
  - `req_ready` = 0.
  - `lat_cnt` decrements each cycle.
  - On the edge where `lat_cnt` = 1, the next state is `RESP`.
- `RESP`:
  - `rsp_valid` = 1 and `rsp_rdata` = `rdata_q`; both are held stable until `rsp_ready`.
  - On `rsp_ready`, the next state is `IDLE`.
  - `req_ready` = 0 while in `RESP`. There is no bypass acceptance in the same cycle as the handshake.
- `busy` = (state != `IDLE`).
- Load data is a snapshot taken at acceptance. No store can intervene, because `req_ready` = 0 while a load is outstanding.
- The store write does not depend on `rsp_ready` or any downstream state.
- `req_write`, `req_addr` and `req_wdata` are ignored when `req_valid` = 0.
- Arithmetic and widths:
  - `lat_cnt` is 2 bits.
  - Addresses are used unmodified (4 bits index 16 words); there is no wrap logic.
  - Data is 4 bits with no extension.

## Timing
- Reset:
  - Takes effect at the rising edge where `rst_n` = 0, including mid-load (`WAIT` or `RESP`).
  - State → `IDLE`, `lat_cnt` → 0, `rdata_q` → 0, all 16 words → 0.
  - Outputs after reset: `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `busy` = 0.
  - A pending response is dropped and is never presented.
  - A request presented in the same cycle as active reset is not accepted and has no effect.
- Store latency: the new value is readable by a load accepted in the next cycle.
- Load latency: a load accepted at edge N asserts `rsp_valid` in the cycle following edge N + `READ_LATENCY` − 1. With the default of 2, the response is visible 2 cycles after the request cycle.
- Throughput:
  - One store per cycle while `IDLE`.
  - Loads: at best one per `READ_LATENCY` + 1 cycles.
- `rsp_ready` held low stalls indefinitely in `RESP`; outputs stay constant.
- `rsp_ready` asserted while `rsp_valid` = 0 has no effect.

## Structure
- Shared package `mips4_pkg`:
  - `DATA_W` = 4 and `ADDR_W` = 4.
  - `resp_state_t` enum {`IDLE`, `WAIT`, `RESP`}.
  - Exported for reuse by the processor-side initiator.
- One sub-module, `data_mem_array`:
  - 16×4 storage with a synchronous write port and combinational read.
  - Synchronous active-low clear that zeroes all words.
  - The FSM, latency counter and handshake logic stay in the top module.

## Test plan
- Reset then idle: hold `rst_n` = 0 for 2 cycles, then release → `req_ready` = 1, `rsp_valid` = 0, `busy` = 0; a load from addr 5 returns 0.
- Store then load: store 0xA to addr 3, then load addr 3 in the next cycle, `rsp_ready` = 1 → `rsp_rdata` = 0xA with `rsp_valid` exactly 2 cycles after the load request cycle; `req_ready` = 0 throughout `WAIT`/`RESP`.
- Backpressure: load addr 7 (holding 0x5) with `rsp_ready` = 0 for 4 cycles → `rsp_valid` = 1 and `rsp_rdata` = 0x5 stable all 4 cycles, and `req_valid` stores presented meanwhile are not accepted (addr 7 still reads 0x5 afterward).
- Back-to-back stores: store 0x1..0xF to addrs 0..14 on consecutive cycles, then read all → each value is correct and no request is stalled.
- Reset mid-load: accept a load of addr 2, assert `rst_n` = 0 in `WAIT` → the next cycle shows `rsp_valid` = 0, `busy` = 0, memory cleared; no response ever appears for that load.
- Latency sweep: run with `READ_LATENCY` = 1 and 4 → `rsp_valid` appears 1 and 4 cycles after the request cycle respectively.
